// File: rtl/program_counter.sv
// program_counter: fetch-address sequencer sitting directly in front of the
// instruction memory. Handles sequential fetch, PC-relative branches,
// absolute jumps, stalls with a pending-redirect slot, and a clean halt when
// the next address would leave the loaded program.
// Optional: define PC_PERF_COUNT_EN to add the 16-bit fetch_count output.
module program_counter #(
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(8)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_offset,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [ADDR_WIDTH-1:0] pc_plus_one,
  output logic                  address_valid,
  output logic                  halted
`ifdef PC_PERF_COUNT_EN
  ,
  output logic [15:0]           fetch_count
`endif
);

  typedef enum logic [1:0] {S_START, S_RUN, S_STALLED, S_HALT} state_t;

  // Redirect held across a stall; the target is stored as an absolute
  // address so a branch is resolved against the (held) address at capture.
  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] tgt;
  } redir_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  redir_t                pend_q, pend_d, cap;
  logic [ADDR_WIDTH:0]   inc;
  logic [ADDR_WIDTH-1:0] br_tgt, live_tgt, rel_tgt;
  logic                  live_halt, rel_halt;

  // Live-input next address: jump > branch > increment, plus halt check.
  // Only a plain increment can carry out; redirects wrap modulo 2^W.
  always_comb begin
    inc         = {1'b0, address} + (ADDR_WIDTH+1)'(1);
    pc_plus_one = inc[ADDR_WIDTH-1:0];
    br_tgt      = pc_plus_one + branch_offset;
    cap.vld     = jump | branch_taken;
    cap.tgt     = jump ? jump_target : br_tgt;
    if (jump) begin
      live_tgt  = jump_target;
      live_halt = jump_target > LAST_ADDR;
    end else if (branch_taken) begin
      live_tgt  = br_tgt;
      live_halt = br_tgt > LAST_ADDR;
    end else begin
      live_tgt  = pc_plus_one;
      live_halt = inc[ADDR_WIDTH] | (pc_plus_one > LAST_ADDR);
    end
  end

  // Next-state / next-address decode; a pending redirect beats live inputs
  // on the cycle the stall drops.
  always_comb begin
    state_d  = state_q;
    addr_d   = address;
    pend_d   = pend_q;
    rel_tgt  = pend_q.vld ? pend_q.tgt : live_tgt;
    rel_halt = pend_q.vld ? (pend_q.tgt > LAST_ADDR) : live_halt;
    case (state_q)
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (stall) begin
          state_d = S_STALLED;
          pend_d  = cap;
        end else if (live_halt) begin
          state_d = S_HALT;
        end else begin
          addr_d  = live_tgt;
        end
      end
      S_STALLED: begin
        if (stall) begin
          if (cap.vld) pend_d = cap;
        end else begin
          pend_d  = '0;
          state_d = rel_halt ? S_HALT : S_RUN;
          if (!rel_halt) addr_d = rel_tgt;
        end
      end
      S_HALT: state_d = S_HALT;
    endcase
  end

  // State, fetch address and pending-redirect registers; reset wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_START;
      address <= RESET_ADDR;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      address <= addr_d;
      pend_q  <= pend_d;
    end
  end

  assign address_valid = (state_q == S_RUN) || (state_q == S_STALLED);
  assign halted        = (state_q == S_HALT);

`ifdef PC_PERF_COUNT_EN
  // Count advancing fetches; saturates, and stops naturally once halted.
  always_ff @(posedge clock) begin
    if (reset)                                           fetch_count <= '0;
    else if (address_valid && !stall && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed tables for each scenario
// plus a randomized run against a behavioural model of the fetch sequence.
module tb_program_counter;

  localparam int AW = 4, MASK = 15, LAST = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0, stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [AW-1:0] branch_offset = '0, jump_target = '0;
  logic [AW-1:0] address, pc_plus_one;
  logic          address_valid, halted;
`ifdef PC_PERF_COUNT_EN
  logic [15:0]   fetch_count;
`endif

  int n_cmp = 0, n_bad = 0;

  // Model: current fetch address, whether fetching, halted, inside a stall,
  // pending redirect target (-1 = none), advancing-fetch count.
  int m_pc = 0, m_pend = -1, m_cnt = 0;
  bit m_live = 0, m_halt = 0, m_held = 0;

  typedef struct {
    bit rst; bit st; bit j; bit b;
    int jt; int off;
    int a; bit v; bit h;
  } vec_t;

  program_counter dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .address(address), .pc_plus_one(pc_plus_one),
    .address_valid(address_valid), .halted(halted)
`ifdef PC_PERF_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clock = ~clock;

  // One clock of the sequencer, described by the fetch rules directly.
  task automatic model_step(input bit rst, input bit st, input bit j, input bit b,
                            input int jt, input int off);
    int nxt;
    bit carry;
    if (rst) begin
      m_pc = 0; m_live = 0; m_halt = 0; m_held = 0; m_pend = -1; m_cnt = 0;
    end else if (!m_halt) begin
      if (!m_live) begin
        m_live = 1;
      end else if (st) begin
        if (j)            m_pend = jt;
        else if (b)       m_pend = (m_pc + 1 + off) & MASK;
        else if (!m_held) m_pend = -1;
        m_held = 1;
      end else begin
        carry = 0;
        if (m_held && m_pend >= 0) nxt = m_pend;
        else if (j)                nxt = jt;
        else if (b)                nxt = (m_pc + 1 + off) & MASK;
        else begin
          nxt = m_pc + 1; carry = nxt > MASK; nxt = nxt & MASK;
        end
        m_held = 0; m_pend = -1;
        if (m_cnt < 65535) m_cnt++;
        if (carry || nxt > LAST) begin m_halt = 1; m_live = 0; end
        else m_pc = nxt;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic tick(input bit rst, input bit st, input bit j, input bit b,
                      input logic [3:0] jt, input logic [3:0] off);
    int offs;
    reset = rst; stall = st; jump = j; branch_taken = b;
    jump_target = jt; branch_offset = off;
    offs = $signed(off);
    model_step(rst, st, j, b, int'(jt), offs);
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 4'd0, 4'd0);
    tick(1, 1, 1, 0, 4'd5, 4'd0);
    n_cmp++;
    if ({address, pc_plus_one, address_valid, halted} !== {4'd0, 4'd1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset got addr=%0d pc1=%0d valid=%b halted=%b want 0 1 0 0",
               address, pc_plus_one, address_valid, halted);
    end
  endtask

  task automatic test_free_run();
    int ea;
    tick(1, 0, 0, 0, 4'd0, 4'd0);
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 0, 4'd0, 4'd0);
      ea = (i < 9) ? i : 8;
      n_cmp++;
      if ({address, pc_plus_one, address_valid, halted} !==
          {4'(ea), 4'(ea + 1), (i < 9), (i >= 9)}) begin
        n_bad++;
        $display("FAIL free_run[%0d] got addr=%0d pc1=%0d valid=%b halted=%b want addr=%0d valid=%b halted=%b",
                 i, address, pc_plus_one, address_valid, halted, ea, i < 9, i >= 9);
      end
    end
  endtask

  task automatic test_jump();
    vec_t tv[9] = '{
      '{1,0,0,0, 0,0, 0,0,0}, '{0,0,0,0, 0,0, 0,1,0}, '{0,0,0,0, 0,0, 1,1,0},
      '{0,0,0,0, 0,0, 2,1,0}, '{0,0,1,0, 6,0, 6,1,0}, '{0,0,0,0, 0,0, 7,1,0},
      '{0,0,0,0, 0,0, 8,1,0}, '{0,0,0,0, 0,0, 8,0,1}, '{0,0,1,0, 2,0, 8,0,1}};
    foreach (tv[i]) begin
      tick(tv[i].rst, tv[i].st, tv[i].j, tv[i].b, 4'(tv[i].jt), 4'(tv[i].off));
      n_cmp++;
      if ({address, address_valid, halted} !== {4'(tv[i].a), tv[i].v, tv[i].h}) begin
        n_bad++;
        $display("FAIL jump[%0d] got addr=%0d valid=%b halted=%b want addr=%0d valid=%b halted=%b",
                 i, address, address_valid, halted, tv[i].a, tv[i].v, tv[i].h);
      end
    end
  endtask

  task automatic test_branch();
    vec_t tv[9] = '{
      '{1,0,0,0, 0,0, 0,0,0}, '{0,0,0,0, 0,0, 0,1,0}, '{0,0,0,0, 0,0, 1,1,0},
      '{0,0,0,0, 0,0, 2,1,0}, '{0,0,0,0, 0,0, 3,1,0}, '{0,0,0,0, 0,0, 4,1,0},
      '{0,0,0,1, 0,14, 3,1,0}, '{0,0,0,0, 0,0, 4,1,0}, '{0,0,0,0, 0,0, 5,1,0}};
    foreach (tv[i]) begin
      tick(tv[i].rst, tv[i].st, tv[i].j, tv[i].b, 4'(tv[i].jt), 4'(tv[i].off));
      n_cmp++;
      if ({address, address_valid, halted} !== {4'(tv[i].a), tv[i].v, tv[i].h}) begin
        n_bad++;
        $display("FAIL branch[%0d] got addr=%0d valid=%b halted=%b want addr=%0d valid=%b halted=%b",
                 i, address, address_valid, halted, tv[i].a, tv[i].v, tv[i].h);
      end
    end
  endtask

  task automatic test_stall_redirect();
    vec_t tv[11] = '{
      '{1,0,0,0, 0,0, 0,0,0}, '{0,0,0,0, 0,0, 0,1,0}, '{0,0,0,0, 0,0, 1,1,0},
      '{0,0,0,0, 0,0, 2,1,0}, '{0,0,0,0, 0,0, 3,1,0}, '{0,1,0,0, 0,0, 3,1,0},
      '{0,1,1,0, 7,0, 3,1,0}, '{0,1,0,0, 0,0, 3,1,0}, '{0,0,0,0, 0,0, 7,1,0},
      '{0,0,0,0, 0,0, 8,1,0}, '{0,0,0,0, 0,0, 8,0,1}};
    foreach (tv[i]) begin
      tick(tv[i].rst, tv[i].st, tv[i].j, tv[i].b, 4'(tv[i].jt), 4'(tv[i].off));
      n_cmp++;
      if ({address, address_valid, halted} !== {4'(tv[i].a), tv[i].v, tv[i].h}) begin
        n_bad++;
        $display("FAIL stall[%0d] got addr=%0d valid=%b halted=%b want addr=%0d valid=%b halted=%b",
                 i, address, address_valid, halted, tv[i].a, tv[i].v, tv[i].h);
      end
    end
  endtask

  // Jump beats branch; reset out of halt behaves like a cold reset.
  task automatic test_priority_reset();
    vec_t tv[11] = '{
      '{1,0,0,0, 0,0, 0,0,0}, '{0,0,0,0, 0,0, 0,1,0}, '{0,0,0,0, 0,0, 1,1,0},
      '{0,0,1,1, 5,3, 5,1,0}, '{0,0,0,0, 0,0, 6,1,0}, '{0,0,0,0, 0,0, 7,1,0},
      '{0,0,0,0, 0,0, 8,1,0}, '{0,0,0,0, 0,0, 8,0,1}, '{1,0,0,0, 0,0, 0,0,0},
      '{0,0,0,0, 0,0, 0,1,0}, '{0,0,0,0, 0,0, 1,1,0}};
    foreach (tv[i]) begin
      tick(tv[i].rst, tv[i].st, tv[i].j, tv[i].b, 4'(tv[i].jt), 4'(tv[i].off));
      n_cmp++;
      if ({address, address_valid, halted} !== {4'(tv[i].a), tv[i].v, tv[i].h}) begin
        n_bad++;
        $display("FAIL priority[%0d] got addr=%0d valid=%b halted=%b want addr=%0d valid=%b halted=%b",
                 i, address, address_valid, halted, tv[i].a, tv[i].v, tv[i].h);
      end
    end
  endtask

  // Jump exactly to LAST, wrap-around branch that halts, pending branch
  // captured on the stall edge beating a live jump, jump past LAST.
  task automatic test_limits();
    vec_t tv[18] = '{
      '{1,0,0,0, 0,0, 0,0,0}, '{0,0,0,0, 0,0, 0,1,0}, '{0,0,1,0, 8,0, 8,1,0},
      '{0,0,1,0, 0,0, 0,1,0}, '{0,0,0,1, 0,13, 0,0,1}, '{1,0,0,0, 0,0, 0,0,0},
      '{0,0,0,0, 0,0, 0,1,0}, '{0,0,1,0, 5,0, 5,1,0}, '{0,1,0,1, 0,1, 5,1,0},
      '{0,1,0,0, 0,0, 5,1,0}, '{0,0,1,0, 0,0, 7,1,0}, '{0,0,1,0, 9,0, 7,0,1},
      '{1,0,0,0, 0,0, 0,0,0}, '{0,0,0,0, 0,0, 0,1,0}, '{0,0,1,0, 8,0, 8,1,0},
      '{0,1,0,0, 0,0, 8,1,0}, '{0,1,0,0, 0,0, 8,1,0}, '{0,0,0,0, 0,0, 8,0,1}};
    foreach (tv[i]) begin
      tick(tv[i].rst, tv[i].st, tv[i].j, tv[i].b, 4'(tv[i].jt), 4'(tv[i].off));
      n_cmp++;
      if ({address, address_valid, halted} !== {4'(tv[i].a), tv[i].v, tv[i].h}) begin
        n_bad++;
        $display("FAIL limits[%0d] got addr=%0d valid=%b halted=%b want addr=%0d valid=%b halted=%b",
                 i, address, address_valid, halted, tv[i].a, tv[i].v, tv[i].h);
      end
    end
  endtask

`ifdef PC_PERF_COUNT_EN
  task automatic test_perf();
    tick(1, 0, 0, 0, 4'd0, 4'd0);
    n_cmp++;
    if (fetch_count !== 16'd0) begin
      n_bad++; $display("FAIL perf_reset got %0d want 0", fetch_count);
    end
    for (int i = 0; i < 18; i++)
      tick(0, (i == 5) || (i == 6), 0, 0, 4'd0, 4'd0);
    n_cmp++;
    if ({halted, fetch_count} !== {1'b1, 16'd9}) begin
      n_bad++; $display("FAIL perf_count got halted=%b count=%0d want 1 9", halted, fetch_count);
    end
  endtask
`endif

  task automatic test_random();
    bit r, s, j, b;
    logic [3:0] jt, off;
    tick(1, 0, 0, 0, 4'd0, 4'd0);
    for (int i = 0; i < 800; i++) begin
      r   = ($urandom_range(0, 99) < 2) || (m_halt && $urandom_range(0, 2) == 0);
      s   = $urandom_range(0, 99) < 25;
      j   = $urandom_range(0, 99) < 15;
      b   = $urandom_range(0, 99) < 20;
      jt  = 4'($urandom_range(0, 9));
      off = 4'($urandom);
      tick(r, s, j, b, jt, off);
      n_cmp++;
      if ({address, pc_plus_one, address_valid, halted} !==
          {4'(m_pc), 4'(m_pc + 1), m_live, m_halt}) begin
        n_bad++;
        $display("FAIL random[%0d] got addr=%0d pc1=%0d valid=%b halted=%b want addr=%0d valid=%b halted=%b",
                 i, address, pc_plus_one, address_valid, halted, m_pc, m_live, m_halt);
      end
`ifdef PC_PERF_COUNT_EN
      n_cmp++;
      if (fetch_count !== 16'(m_cnt)) begin
        n_bad++; $display("FAIL random_count[%0d] got %0d want %0d", i, fetch_count, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_jump();
    test_branch();
    test_stall_redirect();
    test_priority_reset();
    test_limits();
`ifdef PC_PERF_COUNT_EN
    test_perf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Fetch-address sequencer directly upstream of the instruction memory.
- Drives the 4-bit fetch address every cycle.
- Applies sequential increment, PC-relative branch and absolute jump redirects, and stalls.
- Halts cleanly when execution runs past the last loaded instruction slot; the instruction memory never sees an out-of-range address.

Parameters:
- ADDR_WIDTH, 4: width of fetch address; all PC arithmetic is modulo 2^ADDR_WIDTH.
- RESET_ADDR, 0: address issued first after reset.
- LAST_ADDR, 8: highest valid instruction address; any computed next address above it halts the sequencer.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold current address; no advance this cycle.
- branch_taken  input  1  PC-relative redirect request.
- branch_offset  input  ADDR_WIDTH  signed two's-complement offset, relative to address+1.
- jump  input  1  absolute redirect request.
- jump_target  input  ADDR_WIDTH  absolute jump address.
- address  output  ADDR_WIDTH  fetch address to instruction memory.
- pc_plus_one  output  ADDR_WIDTH  address+1 (mod 2^ADDR_WIDTH), combinational, for link/branch use.
- address_valid  output  1  address is a live fetch this cycle.
- halted  output  1  sequencer has stopped.

Behaviour:
- Reset is synchronous, active-high, and has top priority.
- On reset:
  - address=RESET_ADDR, address_valid=0, halted=0.
  - Pending-redirect register cleared.
  - State=START.
- States: START, RUN, STALLED, HALT.
- START: one cycle after reset. Next state RUN with address_valid=1 and address held at RESET_ADDR (first fetch is RESET_ADDR).
- RUN, priority stall > jump > branch_taken > increment:
  - stall=1: address held; redirect inputs captured into the pending register (jump wins over branch); go to STALLED; address_valid stays 1.
  - jump=1: next=jump_target.
  - branch_taken=1: next=address+1+branch_offset (mod 2^ADDR_WIDTH).
  - Otherwise: next=address+1.
- STALLED:
  - Address held while stall=1.
  - A new redirect during stall overwrites any older pending redirect (most recent wins; jump beats branch in the same cycle).
  - First cycle with stall=0: next = pending target if a redirect is pending, else the live-input rule above. Pending register cleared. Return to RUN.
- Halt detection, applied to every computed next address:
  - Halt if next > LAST_ADDR (unsigned), or if a plain increment carries out of ADDR_WIDTH.
  - Then: state=HALT; address holds last valid value; address_valid=0 and halted=1 from the next edge.
- HALT is absorbing; only reset leaves it. All inputs are ignored.
- Latency: redirect requested in cycle N appears on address at cycle N+1 (1-cycle redirect); no delay slot.
- address is registered; pc_plus_one is combinational from address.
- Reset asserted mid-stall or mid-halt: same result as a reset from idle.

Optional Feature:
- Macro PC_PERF_COUNT_EN.
- Defined:
  - Adds output port fetch_count (16 bits), reset to 0.
  - Increments by 1 on each edge where address_valid=1 and the sequencer advances (not stalled).
  - Saturates at 16'hFFFF and freezes on halt.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then 10 free-running cycles -> address 0,0(START),1,2,...,8; cycle after 8: halted=1, address_valid=0, address stays 8.
- At address=2 assert jump, jump_target=6 -> next address 6, then 7, 8, then halt.
- At address=4 assert branch_taken, branch_offset=4'b1110 (-2) -> next address 3 (4+1-2); then 4, 5.
- At address=3 assert stall 3 cycles, with jump to 7 in stall cycle 2 -> address holds 3 three cycles, then 7; redirect not lost.
- jump and branch_taken both high at address=1 (target 5, offset +3) -> address 5 (jump wins); assert reset while halted -> address 0, halted=0 next edge.
- With PC_PERF_COUNT_EN, run to halt from reset with one 2-cycle stall -> fetch_count=9 and stays 9 after halt.
